// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// the illegal-code nibble, FSM encoding and default parameters.
package seg7_pkg;

  localparam int DEFAULT_NUM_DIGITS    = 4;
  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Segment patterns, bit6=g ... bit0=a, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Nibble reported for any pattern that is not a digit 0-9.
  localparam logic [3:0] BCD_ILLEGAL = 4'hF;

  // Frame assembly state: IDLE = no digit captured, COLLECT = some digits
  // captured, COMMIT = one cycle in which the finished frame is published.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode_if.sv
// Bundle of the scan-side inputs and frame-side outputs of seg7_decode.
//
// Handshake: there is no ready/backpressure. iSel/iSeg are sampled every
// cycle. oValid is a single-cycle pulse; oData/oErr are valid while oValid
// is high and then hold that frame until the next pulse, so a consumer may
// also read them at any later time.
interface seg7_decode_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
);

  logic [NUM_DIGITS-1:0]   iSel;
  logic [6:0]              iSeg;
  logic [4*NUM_DIGITS-1:0] oData;
  logic                    oValid;
  logic [NUM_DIGITS-1:0]   oErr;
  state_t                  state_dbg;

  // Driver side (scanning display driver / testbench).
  modport master (
    output iSel,
    output iSeg,
    input  oData,
    input  oValid,
    input  oErr,
    input  state_dbg
  );

  // Decoder side.
  modport slave (
    input  iSel,
    input  iSeg,
    output oData,
    output oValid,
    output oErr,
    output state_dbg
  );

endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD nibble translation; anything
// that is not an exact 0-9 pattern maps to the illegal nibble with oErr set.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] iSeg,
  output logic [3:0] oNibble,
  output logic       oErr
);

  // Exact-match lookup; no partial-segment tolerance.
  always_comb begin
    oNibble = BCD_ILLEGAL;
    oErr    = 1'b0;
    case (iSeg)
      SEG_0:   oNibble = 4'd0;
      SEG_1:   oNibble = 4'd1;
      SEG_2:   oNibble = 4'd2;
      SEG_3:   oNibble = 4'd3;
      SEG_4:   oNibble = 4'd4;
      SEG_5:   oNibble = 4'd5;
      SEG_6:   oNibble = 4'd6;
      SEG_7:   oNibble = 4'd7;
      SEG_8:   oNibble = 4'd8;
      SEG_9:   oNibble = 4'd9;
      default: begin
        oNibble = BCD_ILLEGAL;
        oErr    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_decode.sv
// Reconstructs a multi-digit BCD frame from a multiplexed seven-segment
// scan. Each digit must dwell STABLE_CYCLES identical samples before it is
// captured; once every digit is captured the frame is published with a
// one-cycle oValid pulse.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
)(
  input  logic          iClk,
  input  logic          iRst_n,
  seg7_decode_if.slave  bus
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_W = CNT_W'(STABLE_CYCLES);

  // Sample pipeline: sel_q/seg_q is the sample under evaluation, the _prev_q
  // copy is the one before it.
  logic [NUM_DIGITS-1:0]   sel_q, sel_prev_q;
  logic [6:0]              seg_q, seg_prev_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;
  state_t                  state_q, state_d;

  logic                    same;
  logic                    sel_ok;
  logic                    accept;
  logic                    mask_full;
  logic [3:0]              dec_nibble;
  logic                    dec_err;

  assign same      = (sel_q == sel_prev_q) && (seg_q == seg_prev_q);
  assign sel_ok    = $onehot(sel_q);
  assign mask_full = &mask_d;

  seg7_to_bcd u_to_bcd (
    .iSeg    (seg_q),
    .oNibble (dec_nibble),
    .oErr    (dec_err)
  );

  // Stability counter: zero for an illegal select, restart at 1 on a new
  // sample, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!sel_ok) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != STABLE_W) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Accept only on the cycle the count first lands on the threshold, so a
  // long dwell yields a single capture.
  assign accept = sel_ok && (cnt_d == STABLE_W) && !(same && (cnt_q == STABLE_W));

  // Shadow frame update: the latest accepted pattern for a digit wins; the
  // mask restarts after a commit but still records a same-cycle acceptance.
  always_comb begin
    shadow_d     = shadow_q;
    shadow_err_d = shadow_err_q;
    mask_d       = (state_q == ST_COMMIT) ? '0 : mask_q;
    if (accept) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_q[i]) begin
          shadow_d[4*i +: 4] = dec_nibble;
          shadow_err_d[i]    = dec_err;
        end
      end
      mask_d = mask_d | sel_q;
    end
  end

  // Frame FSM next-state and publish logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = mask_full ? ST_COMMIT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (mask_full) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // shadow_d so an acceptance landing in this cycle is part of the frame.
        data_d  = shadow_d;
        err_d   = shadow_err_d;
        valid_d = 1'b1;
        if (accept) begin
          state_d = mask_full ? ST_COMMIT : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Input sampling and stability counter registers.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sel_q      <= '0;
      seg_q      <= '0;
      sel_prev_q <= '0;
      seg_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      sel_q      <= bus.iSel;
      seg_q      <= bus.iSeg;
      sel_prev_q <= sel_q;
      seg_prev_q <= seg_q;
      cnt_q      <= cnt_d;
    end
  end

  // Frame assembly and output registers.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      mask_q       <= '0;
      shadow_q     <= '0;
      shadow_err_q <= '0;
      data_q       <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      shadow_err_q <= shadow_err_d;
      data_q       <= data_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      state_q      <= state_d;
    end
  end

  assign bus.oData     = data_q;
  assign bus.oErr      = err_q;
  assign bus.oValid    = valid_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/seg7_decode.md
SEG7_DECODE -- requirements
Module: seg7_decode

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits reconstructed.
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical samples required before a digit is accepted.
REQ-003 iClk  input  1  single clock; all logic on rising edge.
REQ-004 iRst_n  input  1  reset, synchronous, active-low.
REQ-005 iSel  input  NUM_DIGITS  digit select from the scanning driver, active-high, legal only when one-hot.
REQ-006 iSeg  input  7  segment pattern g~a (bit6=g, bit0=a), active-high.
REQ-007 oData  output  4*NUM_DIGITS  decoded BCD frame, digit i in bits [4i+3:4i].
REQ-008 oValid  output  1  one-cycle pulse when oData updates with a complete frame.
REQ-009 oErr  output  NUM_DIGITS  per-digit flag, set when that digit's last accepted pattern was not a legal 0-9 code.

Function
REQ-010 Decode table (gfedcba): 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F; any other pattern decodes to 4'hF with error.
REQ-011 Registered sample of {iSel,iSeg} each cycle; stability counter increments when sample equals previous sample, else reloads to 1.
REQ-012 Counter saturates at STABLE_CYCLES; width = clog2(STABLE_CYCLES+1).
REQ-013 Digit accepted on the cycle counter first reaches STABLE_CYCLES with iSel one-hot; exactly one acceptance per dwell, no re-acceptance until sample changes.
REQ-014 iSel zero or multi-hot: counter held at 0, no acceptance, no error flag change.
REQ-015 Acceptance writes decoded nibble into shadow slot i, sets captured-mask bit i, updates shadow error bit i.
REQ-016 Re-acceptance of an already-captured digit within a frame overwrites its shadow slot (latest value wins).
REQ-017 When captured mask becomes all-ones, next cycle: oData <= shadow, oErr <= shadow errors, oValid = 1 for one cycle, mask cleared.
REQ-018 Acceptance coinciding with frame completion cycle is included in the completed frame.
REQ-019 Latency: last digit's final stable sample to oValid = STABLE_CYCLES+2 cycles from first iSel/iSeg presentation at inputs edge (1 sample reg + count + commit).
REQ-020 oData and oErr hold between frames; oValid low otherwise.
REQ-021 FSM states: IDLE (mask empty), COLLECT (mask partial), COMMIT (one cycle, outputs updated); IDLE->COLLECT on first acceptance, COLLECT->COMMIT on full mask, COMMIT->IDLE unconditionally, or COMMIT->COLLECT if an acceptance occurs that cycle.

Reset
REQ-022 iRst_n low at a clock edge: oData=0, oErr=0, oValid=0, mask=0, shadow=0, counter=0, sample regs=0, state=IDLE.
REQ-023 Reset mid-frame discards partial captures; no oValid generated by reset or its release.
REQ-024 First acceptance after reset requires a full STABLE_CYCLES dwell from release.

Structure
REQ-025 Shared package seg7_pkg holds the ten pattern constants, illegal code 4'hF, state encoding, default NUM_DIGITS/STABLE_CYCLES.
REQ-026 One combinational sub-module seg7_to_bcd (7-bit pattern -> 4-bit nibble + error bit), shared in concept with display7 table.
REQ-027 All registers in seg7_decode; no latches, no derived clocks.

Verification
REQ-028 Scan digits 0..3 one-hot with patterns 3F,06,5B,4F, 8 cycles each -> single oValid pulse, oData=16'h3210, oErr=0.
REQ-029 Digit 2 held only 3 cycles then next digit -> digit 2 not accepted, no oValid until digit 2 later dwells 4+ cycles.
REQ-030 Digit 1 pattern 7'h49 (illegal), others legal 7F -> oData=16'h88F8, oErr=4'b0010.
REQ-031 iSel=4'b0011 for 20 cycles -> no acceptance, no oValid, outputs unchanged.
REQ-032 Frame with digit 0 shown twice (06 then 6F) before remaining digits -> committed nibble 0 = 9.
REQ-033 Assert iRst_n=0 after 3 digits captured, release, scan full frame 6D,66,07,7D -> one oValid, oData=16'h6745, no spurious pulse at reset.
